dac_serial_rx: RTL
==================

DAC_SERIAL_RX -- requirements
Module: dac_serial_rx

Interface
REQ-001 Parameter FRAME_BITS, 16, number of data bits per SYNC_n frame, MSB first.
REQ-002 Parameter SYNC_STAGES, 2, flip-flop stages on each serial input (minimum 2).
REQ-003 clk_in  input  1  system clock; all logic is on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 DAC_DATA  input  1  serial data, asynchronous to clk_in.
REQ-006 DAC_SCLK  input  1  serial clock, asynchronous to clk_in.
REQ-007 DAC_SYNC_n  input  1  active-low frame strobe, asynchronous to clk_in.
REQ-008 rx_data  output  FRAME_BITS  last completed frame word.
REQ-009 rx_valid  output  1  rx_data holds an unconsumed word.
REQ-010 rx_ready  input  1  consumer accepts the word when rx_valid and rx_ready are both 1.
REQ-011 frame_err  output  1  one-cycle pulse when a frame is aborted.
REQ-012 overrun  output  1  one-cycle pulse when an unconsumed word is overwritten.

Function
REQ-013 DAC_DATA, DAC_SCLK and DAC_SYNC_n shall each pass through SYNC_STAGES flops, plus one history flop for edge detection.
REQ-014 Operating constraint: clk_in frequency is at least 4x DAC_SCLK frequency; behaviour outside this constraint is undefined.
REQ-015 FSM states: IDLE, SHIFT, WAIT_HI.
REQ-016 IDLE -> SHIFT on a synchronized SYNC_n falling edge; the bit counter clears to 0.
REQ-017 In SHIFT, each synchronized SCLK rising edge with SYNC_n low shifts the synchronized DATA into the LSB of the shift register and increments the counter.
REQ-018 When the counter reaches FRAME_BITS: load rx_data from the shift register on the next clk_in edge, set rx_valid, and go to WAIT_HI.
REQ-019 SYNC_n rising in SHIFT with counter < FRAME_BITS: pulse frame_err, discard the partial word, go to IDLE.
REQ-020 In WAIT_HI, extra SCLK edges are ignored with no error; SYNC_n rising returns the FSM to IDLE.
REQ-021 An SCLK edge and a SYNC_n rise in the same synchronized cycle: the SYNC_n rise takes priority and the edge is not counted.
REQ-022 rx_valid stays high, and rx_data stays stable, until a handshake occurs.
REQ-023 A new word loads while rx_valid=1 and rx_ready=0: the new word overwrites rx_data, rx_valid stays 1, and overrun pulses.
REQ-024 A new word loads in the same cycle as a handshake: the new word is loaded, rx_valid stays 1, and there is no overrun.
REQ-025 Latency: rx_valid rises exactly 1 clk_in cycle after the detected SCLK edge that carries the last bit.

Reset
REQ-026 While reset_n=0: FSM=IDLE, counter=0, shift register=0, rx_data=0, rx_valid=0, frame_err=0, overrun=0, and all synchronizer flops set to their idle levels (SCLK=0, SYNC_n=1, DATA=0).
REQ-027 Reset asserted mid-frame abandons the frame without a frame_err pulse; after release, reception resumes only at the next SYNC_n falling edge.

Configuration
REQ-028 Macro DAC_SERIAL_RX_ERRCNT_EN defined: add output err_count[7:0], a saturating count (stops at 255) of frame_err and overrun pulses combined, cleared by reset.
REQ-029 Macro DAC_SERIAL_RX_ERRCNT_EN undefined: the err_count port and its logic do not exist; all other behaviour is identical.

Structure
REQ-030 Package dac_serial_pkg holds the FSM state enum, the default FRAME_BITS value, and the synchronizer idle-level constants.
REQ-031 One sub-module, dac_serial_sync: an N-stage synchronizer with an edge-detect history flop and a reset-value parameter; one instance per serial input.

Verification
REQ-032 Frame 0xA5C3 at SCLK = clk_in/8 -> rx_data=0xA5C3, rx_valid=1, frame_err=0.
REQ-033 SYNC_n rises after 9 bits -> frame_err pulses once, rx_valid stays 0, rx_data unchanged.
REQ-034 Two frames 0x1234 then 0xFFFF with rx_ready=0 -> one overrun pulse, rx_data=0xFFFF.
REQ-035 rx_ready=1 in the cycle the second word loads -> no overrun, rx_valid stays 1, rx_data=0x0001.
REQ-036 Frame of 20 SCLK edges carrying 0x8001 in the first 16 -> rx_data=0x8001, no frame_err.
REQ-037 reset_n pulsed low after 8 bits, then a full frame 0x00FF -> rx_data=0x00FF, no frame_err (with DAC_SERIAL_RX_ERRCNT_EN defined, err_count=0).

Source files
------------

// File: rtl/dac_serial_pkg.sv
// rtl/dac_serial_pkg.sv - shared types and constants for the DAC serial receiver
//
// Holds the receiver FSM state type, the default frame width and the
// levels each serial-line synchronizer resets to (the idle bus levels).

package dac_serial_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        WAIT_HI = 2'd2
    } state_e;

    localparam int DEFAULT_FRAME_BITS = 16;

    // Idle bus levels: clock low, frame strobe deasserted, data low.
    localparam logic SCLK_IDLE   = 1'b0;
    localparam logic SYNC_N_IDLE = 1'b1;
    localparam logic DATA_IDLE   = 1'b0;

endpackage

// File: rtl/dac_serial_sync.sv
// rtl/dac_serial_sync.sv - N-stage input synchronizer with edge-detect history flop
//
// Ports:
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset; all flops load RST_VAL
//   d_i     asynchronous input
//   q_o     synchronized level (output of the last synchronizer stage)
//   hist_o  q_o delayed by one cycle, for edge detection by the user
// Parameters:
//   STAGES  number of synchronizer flops, must be at least 2
//   RST_VAL level all flops take during reset

module dac_serial_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o,
    output logic hist_o
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {STAGES{RST_VAL}};
            hist_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign hist_o = hist_q;

endmodule

// File: rtl/dac_serial_rx.sv
// rtl/dac_serial_rx.sv - serial DAC-style frame receiver with valid/ready word output
//
// Optional feature macro: DAC_SERIAL_RX_ERRCNT_EN adds err_count.
//
// Ports:
//   clk_in      system clock, rising edge
//   reset_n     asynchronous active-low reset
//   DAC_DATA    serial data (asynchronous), sampled on SCLK rise, MSB first
//   DAC_SCLK    serial clock (asynchronous), at most clk_in/4
//   DAC_SYNC_n  active-low frame strobe (asynchronous)
//   rx_data     last completed frame word
//   rx_valid    rx_data holds an unconsumed word
//   rx_ready    consumer accepts the word when rx_valid & rx_ready
//   frame_err   one-cycle pulse when a frame ends early
//   overrun     one-cycle pulse when an unconsumed word is overwritten
//   err_count   (macro only) saturating count of frame_err + overrun pulses

module dac_serial_rx
    import dac_serial_pkg::*;
#(
    parameter int FRAME_BITS  = DEFAULT_FRAME_BITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_in,
    input  logic                  reset_n,
    input  logic                  DAC_DATA,
    input  logic                  DAC_SCLK,
    input  logic                  DAC_SYNC_n,
    output logic [FRAME_BITS-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  frame_err,
    output logic                  overrun
`ifdef DAC_SERIAL_RX_ERRCNT_EN
    ,
    output logic [7:0]            err_count
`endif
);

    localparam int              CNT_W    = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);

    // ------------------------------------------------------------------
    // Input synchronizers
    // ------------------------------------------------------------------
    logic data_s, data_h;
    logic sclk_s, sclk_h;
    logic sync_s, sync_h;

    dac_serial_sync #(.STAGES(SYNC_STAGES), .RST_VAL(DATA_IDLE)) u_sync_data (
        .clk_i  (clk_in),
        .rst_ni (reset_n),
        .d_i    (DAC_DATA),
        .q_o    (data_s),
        .hist_o (data_h)
    );

    dac_serial_sync #(.STAGES(SYNC_STAGES), .RST_VAL(SCLK_IDLE)) u_sync_sclk (
        .clk_i  (clk_in),
        .rst_ni (reset_n),
        .d_i    (DAC_SCLK),
        .q_o    (sclk_s),
        .hist_o (sclk_h)
    );

    dac_serial_sync #(.STAGES(SYNC_STAGES), .RST_VAL(SYNC_N_IDLE)) u_sync_frm (
        .clk_i  (clk_in),
        .rst_ni (reset_n),
        .d_i    (DAC_SYNC_n),
        .q_o    (sync_s),
        .hist_o (sync_h)
    );

    // Data only needs its level; its history flop has no consumer.
    logic unused_data_hist;
    assign unused_data_hist = data_h;

    // The synchronizers reset to the idle level, so releasing reset while
    // SYNC_n is held low would look like a falling edge. Frame starts are
    // only trusted once every synchronizer and history flop holds a real
    // sample, so a frame cut by reset is never picked up halfway.
    logic [SYNC_STAGES:0] warm_q;

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            warm_q <= '0;
        end else begin
            warm_q <= {warm_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    logic sclk_rise, sync_fall, sync_rise;
    assign sclk_rise = sclk_s & ~sclk_h;
    assign sync_fall = ~sync_s & sync_h & warm_q[SYNC_STAGES];
    assign sync_rise = sync_s & ~sync_h;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic                  frame_err_d;
    logic                  load;

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        load        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sync_fall) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    shift_d = '0;
                end
            end
            SHIFT: begin
                // A strobe rise wins over an SCLK edge seen in the same cycle.
                if (sync_rise) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                    cnt_d       = '0;
                    shift_d     = '0;
                end else if (sclk_rise && !sync_s) begin
                    shift_d = {shift_q[FRAME_BITS-2:0], data_s};
                    cnt_d   = cnt_q + CNT_W'(1);
                    // Last bit: the word is handed out on the same edge that
                    // shifts it in, giving a one-cycle detect-to-valid latency.
                    if (cnt_q == CNT_LAST) begin
                        load    = 1'b1;
                        state_d = WAIT_HI;
                    end
                end
            end
            WAIT_HI: begin
                if (sync_rise) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output word register and status pulses
    // ------------------------------------------------------------------
    logic [FRAME_BITS-1:0] rx_data_q;
    logic                  rx_valid_q;
    logic                  frame_err_q;
    logic                  overrun_q, overrun_d;

    // A word arriving alongside a handshake replaces the consumed one cleanly.
    assign overrun_d = load & rx_valid_q & ~rx_ready;

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            if (load) begin
                rx_data_q  <= shift_d;
                rx_valid_q <= 1'b1;
            end else if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

`ifdef DAC_SERIAL_RX_ERRCNT_EN
    // frame_err and overrun come from mutually exclusive FSM branches, so at
    // most one pulse arrives per cycle.
    logic [7:0] err_count_q;

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            err_count_q <= '0;
        end else if ((frame_err_q || overrun_q) && (err_count_q != 8'hFF)) begin
            err_count_q <= err_count_q + 8'd1;
        end
    end

    assign err_count = err_count_q;
`endif

endmodule
